// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-core MSI snoop bus controller.
// The optional statistics counters are enabled with the COH_BUS_STATS_EN macro.
package coherence_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_RD_MISS = 2'd1,
    OP_WR_MISS = 2'd2,
    OP_INVAL   = 2'd3
  } coh_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SNOOP  = 3'd1,
    ST_RESP   = 3'd2,
    ST_MEM_WB = 3'd3,
    ST_MEM_RD = 3'd4,
    ST_DONE   = 3'd5
  } bus_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_req_latch.sv
// Per-core request latch: holds one outstanding miss/invalidate with its address.
// A pulse arriving in the clearing (DONE) cycle re-arms the latch with the new request.
module coh_req_latch
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              inv_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              clr_i,
  output logic              pending_o,
  output coh_op_t           op_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              pend_q, pend_d;
  coh_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    pend_d = pend_q;
    op_d   = op_q;
    addr_d = addr_q;
    if (clr_i) pend_d = 1'b0;
    // A pulse is only accepted when the slot is free or being freed this cycle.
    if ((rd_i || wr_i || inv_i) && (!pend_q || clr_i)) begin
      pend_d = 1'b1;
      addr_d = addr_i;
      if (wr_i)      op_d = OP_WR_MISS;
      else if (rd_i) op_d = OP_RD_MISS;
      else           op_d = OP_INVAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
      op_q   <= OP_NONE;
      addr_q <= '0;
    end else begin
      pend_q <= pend_d;
      op_q   <= op_d;
      addr_q <= addr_d;
    end
  end

  assign pending_o = pend_q;
  assign op_o      = op_q;
  assign addr_o    = addr_q;

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snoop-bus responder for a two-core MSI system: arbitrates core requests, snoops the peer,
// fills from peer or memory, writes back dirty peer data. Optional stats: COH_BUS_STATS_EN.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        rd_miss,
  input  logic [1:0]        wr_miss,
  input  logic [1:0]        inval,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [ADDR_W-1:0] req_addr_1,
  output logic [1:0]        snoop_search,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic [1:0]        snoop_op,
  input  logic              snoop_found_0,
  input  logic              snoop_found_1,
  input  logic              snoop_dirty_0,
  input  logic              snoop_dirty_1,
  input  logic [DATA_W-1:0] snoop_data_0,
  input  logic [DATA_W-1:0] snoop_data_1,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic [1:0]        done,
  output logic [DATA_W-1:0] fill_data,
  output logic [15:0]       peer_fills,
  output logic [15:0]       mem_fills,
  output logic [2:0]        dbg_state_o
);

  logic [1:0]        pend;
  logic [1:0]        clr;
  coh_op_t           lop   [2];
  logic [ADDR_W-1:0] laddr [2];
  logic [ADDR_W-1:0] core_addr [2];

  assign core_addr[0] = req_addr_0;
  assign core_addr[1] = req_addr_1;

  for (genvar c = 0; c < 2; c++) begin : g_latch
    coh_req_latch #(.ADDR_W(ADDR_W)) u_latch (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_i      (rd_miss[c]),
      .wr_i      (wr_miss[c]),
      .inv_i     (inval[c]),
      .addr_i    (core_addr[c]),
      .clr_i     (clr[c]),
      .pending_o (pend[c]),
      .op_o      (lop[c]),
      .addr_o    (laddr[c])
    );
  end

  bus_state_t        state_q, state_d;
  logic              core_q, core_d;
  logic              rr_q, rr_d;
  logic              served_q, served_d;
  coh_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] fill_q, fill_d;
  logic              from_mem_q, from_mem_d;

  logic              peer_found, peer_dirty, pick;
  logic [DATA_W-1:0] peer_data;

  // The peer of core c is core !c.
  assign peer_found = core_q ? snoop_found_0 : snoop_found_1;
  assign peer_dirty = core_q ? snoop_dirty_0 : snoop_dirty_1;
  assign peer_data  = core_q ? snoop_data_0  : snoop_data_1;

  // Until the first completion there is no last-served core, so core 0 wins a tie.
  assign pick = (&pend) ? (served_q ? ~rr_q : 1'b0) : pend[1];

  always_comb begin
    state_d      = state_q;
    core_d       = core_q;
    rr_d         = rr_q;
    served_d     = served_q;
    op_d         = op_q;
    addr_d       = addr_q;
    fill_d       = fill_q;
    from_mem_d   = from_mem_q;
    clr          = 2'b00;
    snoop_search = 2'b00;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    done         = 2'b00;
    unique case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          core_d  = pick;
          op_d    = lop[pick];
          addr_d  = laddr[pick];
          state_d = ST_SNOOP;
        end
      end
      ST_SNOOP: begin
        snoop_search[~core_q] = 1'b1;
        state_d               = ST_RESP;
      end
      ST_RESP: begin
        from_mem_d = 1'b0;
        if (op_q == OP_INVAL) begin
          fill_d  = '0;
          state_d = ST_DONE;
        end else if (peer_found) begin
          fill_d  = peer_data;
          state_d = peer_dirty ? ST_MEM_WB : ST_DONE;
        end else begin
          from_mem_d = 1'b1;
          state_d    = ST_MEM_RD;
        end
      end
      ST_MEM_WB: begin
        mem_we = 1'b1;
        if (mem_rdy) state_d = ST_DONE;
      end
      ST_MEM_RD: begin
        mem_re = 1'b1;
        if (mem_rdy) begin
          fill_d  = mem_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done[core_q] = 1'b1;
        clr[core_q]  = 1'b1;
        rr_d         = core_q;
        served_d     = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      core_q     <= 1'b0;
      rr_q       <= 1'b0;
      served_q   <= 1'b0;
      op_q       <= OP_NONE;
      addr_q     <= '0;
      fill_q     <= '0;
      from_mem_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_q     <= core_d;
      rr_q       <= rr_d;
      served_q   <= served_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      fill_q     <= fill_d;
      from_mem_q <= from_mem_d;
    end
  end

  // Snoop op/addr stay registered from SNOOP until the next transaction is picked.
  assign snoop_addr  = addr_q;
  assign snoop_op    = op_q;
  assign mem_addr    = (state_q == ST_MEM_WB || state_q == ST_MEM_RD) ? addr_q : '0;
  assign mem_wdata   = (state_q == ST_MEM_WB) ? fill_q : '0;
  assign fill_data   = (state_q == ST_DONE) ? fill_q : '0;
  assign dbg_state_o = state_q;

`ifdef COH_BUS_STATS_EN
  logic [STAT_W-1:0] peer_cnt_q, mem_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peer_cnt_q <= '0;
      mem_cnt_q  <= '0;
    end else if (state_q == ST_DONE && op_q != OP_INVAL) begin
      if (from_mem_q) mem_cnt_q  <= sat_inc(mem_cnt_q);
      else            peer_cnt_q <= sat_inc(peer_cnt_q);
    end
  end

  assign peer_fills = peer_cnt_q;
  assign mem_fills  = mem_cnt_q;
`else
  assign peer_fills = '0;
  assign mem_fills  = '0;
`endif

endmodule
